// File: rtl/hilo_mdu.sv
// hilo_mdu: HI/LO multiply-divide unit.
// Multiplies go through a MUL_STAGES-deep product pipeline; MADD/MSUB
// accumulate into HI/LO when the product commits. Divides run a restoring
// shift-subtract loop, one bit per cycle, and apply signs in a final FIX state.
module hilo_mdu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  input  logic             hilo_access_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned DW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMadd  = 4'd5;
  localparam logic [3:0] OpMaddu = 4'd6;
  localparam logic [3:0] OpMsub  = 4'd7;
  localparam logic [3:0] OpMsubu = 4'd8;
  localparam logic [3:0] OpMthi  = 4'd9;
  localparam logic [3:0] OpMtlo  = 4'd10;

  // How a finished product is folded into HI/LO
  localparam logic [1:0] AccSet = 2'd0;
  localparam logic [1:0] AccAdd = 2'd1;
  localparam logic [1:0] AccSub = 2'd2;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;
  logic [1:0]       acc_q;

  // Product pipeline
  logic [DW-1:0]         pipe_q [MUL_STAGES];
  logic [MUL_STAGES-1:0] vld_q;

  // Divider state
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] a_raw_q;
  logic             q_neg_q;
  logic             r_neg_q;
  logic             dvsr_zero_q;
  logic [CntW-1:0]  cnt_q;

  // Decode
  logic       op_mul, op_div, op_signed, op_mthi, op_mtlo;
  logic [1:0] op_acc;
  logic       can_accept;
  logic       acc_mul, acc_div, acc_mthi, acc_mtlo;

  // Datapath
  logic [DW-1:0]    a_ext, b_ext, product;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [DW-1:0]    mul_res;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             mul_commit;

  assign busy_o  = (state_q != StIdle);
  assign ready_o = ~busy_o;
  assign stall_o = busy_o & hilo_access_i;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  // Opcode decode; undefined codes fall through as NOP
  always_comb begin
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
    op_acc    = AccSet;
    case (op_i)
      OpMult:  begin op_mul = 1'b1; op_signed = 1'b1; end
      OpMultu: begin op_mul = 1'b1; end
      OpDiv:   begin op_div = 1'b1; op_signed = 1'b1; end
      OpDivu:  begin op_div = 1'b1; end
      OpMadd:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = AccAdd; end
      OpMaddu: begin op_mul = 1'b1; op_acc = AccAdd; end
      OpMsub:  begin op_mul = 1'b1; op_signed = 1'b1; op_acc = AccSub; end
      OpMsubu: begin op_mul = 1'b1; op_acc = AccSub; end
      OpMthi:  begin op_mthi = 1'b1; end
      OpMtlo:  begin op_mtlo = 1'b1; end
      default: ;
    endcase
  end

  // Acceptance qualifiers: a start while busy or flushing is simply dropped
  always_comb begin
    can_accept = start_i & ready_o & ~flush_i;
    acc_mul    = can_accept & op_mul;
    acc_div    = can_accept & op_div;
    acc_mthi   = can_accept & op_mthi;
    acc_mtlo   = can_accept & op_mtlo;
  end

  // Operand extension, full-width product and divider operand magnitudes
  always_comb begin
    a_ext   = op_signed ? {{WIDTH{src_a_i[WIDTH-1]}}, src_a_i} : {{WIDTH{1'b0}}, src_a_i};
    b_ext   = op_signed ? {{WIDTH{src_b_i[WIDTH-1]}}, src_b_i} : {{WIDTH{1'b0}}, src_b_i};
    product = a_ext * b_ext;
    a_neg   = op_signed & src_a_i[WIDTH-1];
    b_neg   = op_signed & src_b_i[WIDTH-1];
    // -MIN wraps to MIN, which reads correctly as the unsigned magnitude 2^(WIDTH-1)
    a_mag   = a_neg ? -src_a_i : src_a_i;
    b_mag   = b_neg ? -src_b_i : src_b_i;
  end

  // One restoring division step: shift in the next dividend bit, trial-subtract
  always_comb begin
    r_shift = {rem_q, quo_q[WIDTH-1]};
    diff    = r_shift - {1'b0, dvsr_q};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = r_shift[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Commit values for both the multiply and divide paths
  always_comb begin
    mul_commit = vld_q[MUL_STAGES-1];
    case (acc_q)
      AccAdd:  mul_res = {hi_q, lo_q} + pipe_q[MUL_STAGES-1];
      AccSub:  mul_res = {hi_q, lo_q} - pipe_q[MUL_STAGES-1];
      default: mul_res = pipe_q[MUL_STAGES-1];
    endcase
    if (dvsr_zero_q) begin
      fix_lo = '1;
      fix_hi = a_raw_q;
    end else begin
      fix_lo = q_neg_q ? -quo_q : quo_q;
      fix_hi = r_neg_q ? -rem_q : rem_q;
    end
  end

  // Product pipeline; flush discards every stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      if (flush_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= acc_mul;
        for (int i = 1; i < MUL_STAGES; i++) vld_q[i] <= vld_q[i-1];
      end
      if (acc_mul) pipe_q[0] <= product;
      for (int i = 1; i < MUL_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Control FSM with HI/LO, done pulse and divider registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      acc_q       <= AccSet;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      a_raw_q     <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dvsr_zero_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (acc_mthi) hi_q <= src_a_i;
          if (acc_mtlo) lo_q <= src_a_i;
          if (acc_mul) begin
            acc_q   <= op_acc;
            state_q <= StMul;
          end
          if (acc_div) begin
            rem_q       <= '0;
            quo_q       <= a_mag;
            dvsr_q      <= b_mag;
            a_raw_q     <= src_a_i;
            q_neg_q     <= a_neg ^ b_neg;
            r_neg_q     <= a_neg;
            dvsr_zero_q <= (src_b_i == '0);
            cnt_q       <= '0;
            state_q     <= StDiv;
          end
        end
        StMul: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else if (mul_commit) begin
            {hi_q, lo_q} <= mul_res;
            done_q       <= 1'b1;
            state_q      <= StIdle;
          end
        end
        StDiv: begin
          if (flush_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) state_q <= StFix;
          end
        end
        StFix: begin
          cnt_q   <= '0;
          state_q <= StIdle;
          if (!flush_i) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
